jesd204b_prbs_generator: RTL and testbench

// - Transmit-side PRBS7 lane test source for JESD204B link bring-up and BER runs, one 32-bit word per link_clk.
// - Sits in front of the transceiver TX parallel interface, opposite the lane PRBS7 verifier.
// - Streams the alignment word while the receiver requests sync, then free-running PRBS7 (x^7+x^6+1).

---
 rtl/jesd204b_prbs_generator.sv | 148 ++++++++++++++
 tb/tb_jesd204b_prbs_generator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204b_prbs_generator.sv
// rtl/jesd204b_prbs_generator.sv - JESD204B transmit-side PRBS7 (x^7+x^6+1) lane test source
//
// Emits one 32-bit word per link_clk. It sends the alignment word while the
// receiver requests sync, and free-running PRBS7 otherwise.
// Optional feature macro: PRBS_ERR_INJECT_EN (adds err_inject / inj_cnt).
//
// Ports:
//   link_clk          in   1   lane parallel clock, rising edge
//   link_reset_b      in   1   async active-low reset
//   enable            in   1   1 = run, 0 = IDLE
//   sync              in   1   0 = alignment requested, 1 = aligned (already in link_clk domain)
//   tx_parallel_data  out  32  word to transceiver, bit0 first on the wire
//   tx_datak          out  4   per-byte control flags
//   prbs_active       out  1   PRBS words on tx_parallel_data
//   word_cnt          out  32  PRBS words since last alignment, saturating
//   err_inject        in   1   (PRBS_ERR_INJECT_EN) invert bit0 of next PRBS word
//   inj_cnt           out  16  (PRBS_ERR_INJECT_EN) injected error count, saturating

module jesd204b_prbs_generator #(
  parameter logic [31:0] SYNC_WORD  = 32'h4f143040,
  parameter logic [3:0]  SYNC_DATAK = 4'h2,
  parameter int unsigned SYNC_WORDS = 4,
  parameter logic [6:0]  SEED       = 7'h01,
  parameter logic [31:0] IDLE_WORD  = 32'h0
) (
  input  logic        link_clk,
  input  logic        link_reset_b,
  input  logic        enable,
  input  logic        sync,
  output logic [31:0] tx_parallel_data,
  output logic [3:0]  tx_datak,
  output logic        prbs_active,
  output logic [31:0] word_cnt
`ifdef PRBS_ERR_INJECT_EN
  ,
  input  logic        err_inject,
  output logic [15:0] inj_cnt
`endif
);

  localparam logic [3:0] SYNC_WORDS_L = 4'(SYNC_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_PRBS  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [6:0]  lfsr;
  logic [3:0]  sync_cnt;
  logic [6:0]  lfsr_adv;
  logic [31:0] prbs_word;
  logic [31:0] prbs_out;

  // 32 serial LFSR steps unrolled into one cycle; returns {next_lfsr, word}.
  function automatic logic [38:0] prbs_step32(input logic [6:0] seed_in);
    logic [6:0]  r;
    logic [31:0] w;
    r = seed_in;
    w = '0;
    for (int k = 0; k < 32; k++) begin
      w[k] = r[6];
      r    = {r[5:0], r[6] ^ r[5]};
    end
    return {r, w};
  endfunction

  assign {lfsr_adv, prbs_word} = prbs_step32(lfsr);

`ifdef PRBS_ERR_INJECT_EN
  // Corruption is on the output only, so the LFSR sequence is undisturbed.
  assign prbs_out = prbs_word ^ {31'b0, err_inject};
`else
  assign prbs_out = prbs_word;
`endif

  // sync_cnt already counts the alignment word currently on the output.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_ALIGN;
      ST_ALIGN: if (sync && (sync_cnt >= SYNC_WORDS_L)) state_nxt = ST_PRBS;
      ST_PRBS:  if (!sync) state_nxt = ST_ALIGN;
      default:  state_nxt = ST_IDLE;
    endcase
    if (!enable) state_nxt = ST_IDLE;
  end

  // Outputs are driven from state_nxt so they reflect the state entered on this edge.
  always_ff @(posedge link_clk or negedge link_reset_b) begin
    if (!link_reset_b) begin
      state            <= ST_IDLE;
      tx_parallel_data <= IDLE_WORD;
      tx_datak         <= 4'h0;
      prbs_active      <= 1'b0;
      word_cnt         <= 32'h0;
      lfsr             <= SEED;
      sync_cnt         <= 4'h0;
    end else begin
      state <= state_nxt;
      case (state_nxt)
        ST_ALIGN: begin
          tx_parallel_data <= SYNC_WORD;
          tx_datak         <= SYNC_DATAK;
          prbs_active      <= 1'b0;
          lfsr             <= SEED;
          word_cnt         <= 32'h0;
          // Fresh entry counts this word as the first one.
          if (state != ST_ALIGN)
            sync_cnt <= 4'd1;
          else if (sync_cnt != 4'hF)
            sync_cnt <= sync_cnt + 4'd1;
        end
        ST_PRBS: begin
          tx_parallel_data <= prbs_out;
          tx_datak         <= 4'h0;
          prbs_active      <= 1'b1;
          lfsr             <= lfsr_adv;
          sync_cnt         <= 4'h0;
          if (word_cnt != 32'hFFFF_FFFF)
            word_cnt <= word_cnt + 32'd1;
        end
        default: begin
          tx_parallel_data <= IDLE_WORD;
          tx_datak         <= 4'h0;
          prbs_active      <= 1'b0;
          lfsr             <= SEED;
          sync_cnt         <= 4'h0;
        end
      endcase
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  always_ff @(posedge link_clk or negedge link_reset_b) begin
    if (!link_reset_b) begin
      inj_cnt <= 16'h0;
    end else if ((state_nxt == ST_ALIGN) && (state != ST_ALIGN)) begin
      inj_cnt <= 16'h0;
    end else if ((state_nxt == ST_PRBS) && err_inject && (inj_cnt != 16'hFFFF)) begin
      inj_cnt <= inj_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jesd204b_prbs_generator.sv
// tb/tb_jesd204b_prbs_generator.sv - self-checking bench for jesd204b_prbs_generator

module tb_jesd204b_prbs_generator;

  localparam logic [31:0] SYNC_W  = 32'h4f143040;
  localparam logic [6:0]  SEED_V  = 7'h01;

  logic        link_clk;
  logic        link_reset_b;
  logic        enable;
  logic        sync;
  logic [31:0] tx_parallel_data;
  logic [3:0]  tx_datak;
  logic        prbs_active;
  logic [31:0] word_cnt;
`ifdef PRBS_ERR_INJECT_EN
  logic        err_inject;
  logic [15:0] inj_cnt;
`endif

  int         n_cmp = 0;
  int         n_err = 0;
  logic [6:0] m_lfsr;

  jesd204b_prbs_generator dut (
    .link_clk         (link_clk),
    .link_reset_b     (link_reset_b),
    .enable           (enable),
    .sync             (sync),
    .tx_parallel_data (tx_parallel_data),
    .tx_datak         (tx_datak),
    .prbs_active      (prbs_active),
    .word_cnt         (word_cnt)
`ifdef PRBS_ERR_INJECT_EN
    ,
    .err_inject       (err_inject),
    .inj_cnt          (inj_cnt)
`endif
  );

  initial begin
    link_clk = 1'b0;
    forever #5 link_clk = ~link_clk;
  end

  // Serial reference of x^7+x^6+1: out = r[6], shift in r[6]^r[5]; bit k = k-th output.
  function automatic logic [31:0] ref_word(input logic [6:0] r_in, output logic [6:0] r_out);
    logic [6:0]  r;
    logic [31:0] w;
    r = r_in;
    w = '0;
    for (int k = 0; k < 32; k++) begin
      w[k] = r[6];
      r    = {r[5:0], r[6] ^ r[5]};
    end
    r_out = r;
    return w;
  endfunction

  task automatic tick();
    @(posedge link_clk);
    #1;
  endtask

  task automatic test_reset();
    link_reset_b = 1'b0;
    enable       = 1'b0;
    sync         = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    err_inject   = 1'b0;
`endif
    repeat (2) @(posedge link_clk);
    #1;
    n_cmp++; if (tx_parallel_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h exp %h", tx_parallel_data, 32'h0); end
    n_cmp++; if (tx_datak !== 4'h0) begin n_err++; $display("FAIL reset_datak got %h exp %h", tx_datak, 4'h0); end
    n_cmp++; if (prbs_active !== 1'b0) begin n_err++; $display("FAIL reset_active got %b exp 0", prbs_active); end
    n_cmp++; if (word_cnt !== 32'h0) begin n_err++; $display("FAIL reset_word_cnt got %0d exp 0", word_cnt); end
`ifdef PRBS_ERR_INJECT_EN
    n_cmp++; if (inj_cnt !== 16'h0) begin n_err++; $display("FAIL reset_inj_cnt got %0d exp 0", inj_cnt); end
`endif
    link_reset_b = 1'b1;
    tick();
    tick();
    n_cmp++; if ({tx_parallel_data, tx_datak, prbs_active} !== {32'h0, 4'h0, 1'b0})
      begin n_err++; $display("FAIL idle_disabled got %h/%h/%b exp 0/0/0", tx_parallel_data, tx_datak, prbs_active); end
  endtask

  task automatic test_align_default();
    logic [31:0] exp;
    sync   = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if ({tx_parallel_data, tx_datak, prbs_active} !== {SYNC_W, 4'h2, 1'b0})
        begin n_err++; $display("FAIL align_sync_word[%0d] got %h/%h/%b exp %h/2/0", i, tx_parallel_data, tx_datak, prbs_active, SYNC_W); end
    end
    tick();
    n_cmp++; if ({tx_parallel_data, tx_datak, prbs_active} !== {32'h4F143040, 4'h0, 1'b1})
      begin n_err++; $display("FAIL align_first_prbs got %h/%h/%b exp 4f143040/0/1", tx_parallel_data, tx_datak, prbs_active); end
    n_cmp++; if (word_cnt !== 32'd1) begin n_err++; $display("FAIL align_word_cnt got %0d exp 1", word_cnt); end
    m_lfsr = SEED_V;
    exp = ref_word(m_lfsr, m_lfsr);
    for (int i = 1; i < 6; i++) begin
      tick();
      exp = ref_word(m_lfsr, m_lfsr);
      n_cmp++; if (tx_parallel_data !== exp) begin n_err++; $display("FAIL align_prbs[%0d] got %h exp %h", i, tx_parallel_data, exp); end
    end
    n_cmp++; if (word_cnt !== 32'd6) begin n_err++; $display("FAIL align_word_cnt6 got %0d exp 6", word_cnt); end
    enable = 1'b0;
    tick();
    n_cmp++; if ({tx_parallel_data, tx_datak, prbs_active} !== {32'h0, 4'h0, 1'b0})
      begin n_err++; $display("FAIL disable_idle got %h/%h/%b exp 0/0/0", tx_parallel_data, tx_datak, prbs_active); end
    n_cmp++; if (word_cnt !== 32'd6) begin n_err++; $display("FAIL disable_word_cnt_held got %0d exp 6", word_cnt); end
  endtask

  task automatic test_align_extended();
    logic [31:0] exp;
    logic [31:0] w0;
    logic [31:0] w127;
    w0     = '0;
    w127   = '0;
    enable = 1'b1;
    sync   = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      n_cmp++; if ({tx_parallel_data, tx_datak} !== {SYNC_W, 4'h2})
        begin n_err++; $display("FAIL ext_sync_word[%0d] got %h/%h exp %h/2", i, tx_parallel_data, tx_datak, SYNC_W); end
    end
    sync   = 1'b1;
    m_lfsr = SEED_V;
    for (int i = 0; i < 128; i++) begin
      tick();
      exp = ref_word(m_lfsr, m_lfsr);
      if (i == 0) w0 = tx_parallel_data;
      if (i == 127) w127 = tx_parallel_data;
      n_cmp++; if ({tx_parallel_data, tx_datak, prbs_active} !== {exp, 4'h0, 1'b1})
        begin n_err++; $display("FAIL ext_prbs[%0d] got %h/%h/%b exp %h/0/1", i, tx_parallel_data, tx_datak, prbs_active, exp); end
    end
    n_cmp++; if (w0 !== 32'h4F143040) begin n_err++; $display("FAIL ext_word0 got %h exp 4f143040", w0); end
    n_cmp++; if (w127 !== w0) begin n_err++; $display("FAIL ext_period127 got %h exp %h", w127, w0); end
    n_cmp++; if (word_cnt !== 32'd128) begin n_err++; $display("FAIL ext_word_cnt got %0d exp 128", word_cnt); end
  endtask

  task automatic test_resync();
    logic [31:0] exp;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    sync   = 1'b1;
    repeat (4) tick();
    m_lfsr = SEED_V;
    for (int i = 0; i < 200; i++) begin
      tick();
      exp = ref_word(m_lfsr, m_lfsr);
      n_cmp++; if (tx_parallel_data !== exp) begin n_err++; $display("FAIL resync_prbs[%0d] got %h exp %h", i, tx_parallel_data, exp); end
    end
    n_cmp++; if (word_cnt !== 32'd200) begin n_err++; $display("FAIL resync_word_cnt200 got %0d exp 200", word_cnt); end
    sync = 1'b0;
    tick();
    sync = 1'b1;
    n_cmp++; if ({tx_parallel_data, tx_datak, prbs_active} !== {SYNC_W, 4'h2, 1'b0})
      begin n_err++; $display("FAIL resync_drop got %h/%h/%b exp %h/2/0", tx_parallel_data, tx_datak, prbs_active, SYNC_W); end
    n_cmp++; if (word_cnt !== 32'd0) begin n_err++; $display("FAIL resync_word_cnt_clr got %0d exp 0", word_cnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({tx_parallel_data, tx_datak} !== {SYNC_W, 4'h2})
        begin n_err++; $display("FAIL resync_sync_word[%0d] got %h/%h exp %h/2", i, tx_parallel_data, tx_datak, SYNC_W); end
    end
    tick();
    n_cmp++; if ({tx_parallel_data, tx_datak, prbs_active} !== {32'h4F143040, 4'h0, 1'b1})
      begin n_err++; $display("FAIL resync_restart got %h/%h/%b exp 4f143040/0/1", tx_parallel_data, tx_datak, prbs_active); end
    n_cmp++; if (word_cnt !== 32'd1) begin n_err++; $display("FAIL resync_word_cnt1 got %0d exp 1", word_cnt); end
  endtask

  task automatic test_long_run();
    logic [31:0] exp;
    m_lfsr = SEED_V;
    exp = ref_word(m_lfsr, m_lfsr);
    for (int i = 1; i <= 10000; i++) begin
      tick();
      exp = ref_word(m_lfsr, m_lfsr);
      n_cmp++; if (tx_parallel_data !== exp) begin n_err++; $display("FAIL long_prbs[%0d] got %h exp %h", i, tx_parallel_data, exp); end
    end
    n_cmp++; if (word_cnt !== 32'd10001) begin n_err++; $display("FAIL long_word_cnt got %0d exp 10001", word_cnt); end
    enable = 1'b0;
    tick();
    n_cmp++; if ({tx_parallel_data, tx_datak, prbs_active} !== {32'h0, 4'h0, 1'b0})
      begin n_err++; $display("FAIL long_disable got %h/%h/%b exp 0/0/0", tx_parallel_data, tx_datak, prbs_active); end
  endtask

  task automatic test_sync_race();
    enable = 1'b1;
    sync   = 1'b1;
    repeat (4) tick();
    sync = 1'b0;
    tick();
    n_cmp++; if ({tx_parallel_data, tx_datak, prbs_active} !== {SYNC_W, 4'h2, 1'b0})
      begin n_err++; $display("FAIL race_stay_align got %h/%h/%b exp %h/2/0", tx_parallel_data, tx_datak, prbs_active, SYNC_W); end
    sync = 1'b1;
    tick();
    n_cmp++; if ({tx_parallel_data, tx_datak, prbs_active} !== {32'h4F143040, 4'h0, 1'b1})
      begin n_err++; $display("FAIL race_then_prbs got %h/%h/%b exp 4f143040/0/1", tx_parallel_data, tx_datak, prbs_active); end
  endtask

  task automatic test_async_reset();
    repeat (2) tick();
    #2;
    link_reset_b = 1'b0;
    #1;
    n_cmp++; if ({tx_parallel_data, tx_datak, prbs_active} !== {32'h0, 4'h0, 1'b0})
      begin n_err++; $display("FAIL async_reset_out got %h/%h/%b exp 0/0/0", tx_parallel_data, tx_datak, prbs_active); end
    n_cmp++; if (word_cnt !== 32'd0) begin n_err++; $display("FAIL async_reset_word_cnt got %0d exp 0", word_cnt); end
    #1;
    link_reset_b = 1'b1;
    tick();
    n_cmp++; if ({tx_parallel_data, tx_datak, prbs_active} !== {SYNC_W, 4'h2, 1'b0})
      begin n_err++; $display("FAIL async_resume_align got %h/%h/%b exp %h/2/0", tx_parallel_data, tx_datak, prbs_active, SYNC_W); end
  endtask

`ifdef PRBS_ERR_INJECT_EN
  task automatic test_err_inject();
    logic [31:0] exp;
    logic        inj;
    enable = 1'b0;
    tick();
    enable     = 1'b1;
    sync       = 1'b1;
    err_inject = 1'b1;
    repeat (3) tick();
    err_inject = 1'b0;
    tick();
    n_cmp++; if (inj_cnt !== 16'd0) begin n_err++; $display("FAIL inj_ignored_align got %0d exp 0", inj_cnt); end
    m_lfsr = SEED_V;
    for (int i = 0; i < 20; i++) begin
      inj        = (i == 3) || (i == 7) || (i == 12);
      err_inject = inj;
      tick();
      err_inject = 1'b0;
      exp = ref_word(m_lfsr, m_lfsr) ^ {31'b0, inj};
      n_cmp++; if (tx_parallel_data !== exp) begin n_err++; $display("FAIL inj_word[%0d] got %h exp %h", i, tx_parallel_data, exp); end
    end
    n_cmp++; if (inj_cnt !== 16'd3) begin n_err++; $display("FAIL inj_cnt got %0d exp 3", inj_cnt); end
    sync = 1'b0;
    tick();
    sync = 1'b1;
    n_cmp++; if (inj_cnt !== 16'd0) begin n_err++; $display("FAIL inj_cnt_clr got %0d exp 0", inj_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_align_default();
    test_align_extended();
    test_resync();
    test_long_run();
    test_sync_race();
    test_async_reset();
`ifdef PRBS_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
